clock_step_controller: RTL
==========================

// Module: clock_step_controller
// PURPOSE
//  Sequences the pipeline's reduced-rate clocking: emits a one-cycle clock_enable pulse every RATIO
//  fast-clock cycles and a divided clock_out toggling on each pulse. Adds run/halt/single-step control
//  and glitch-free ratio reprogramming. Sits between the board clock and the pipeline stage enables.
// PARAMETERS
//  CNT_W          6   width of the period counter and the ratio
//  DEFAULT_RATIO  2   active ratio after reset; must be 1..2**CNT_W-1
// PORTS
//  clock_in       in   1      fast clock; all state updates on negedge, as in the existing divider
//  reset_n        in   1      asynchronous, active-low reset
//  ratio_in       in   CNT_W  requested period in fast cycles
//  ratio_load     in   1      capture ratio_in into the shadow ratio this cycle
//  run_req        in   1      start free-running enables
//  halt_req       in   1      stop at the next period boundary
//  step_req       in   1      issue exactly one enable period while halted
//  clock_enable   out  1      one-cycle pulse at the end of each period
//  clock_out      out  1      divided clock, toggles on every clock_enable; period is 2*ratio cycles
//  counter_out    out  CNT_W  current period count
//  state_out      out  2      FSM state: 0 HALTED, 1 RUNNING, 2 STEP, 3 DRAIN
//  ratio_err      out  1      one-cycle pulse when ratio_load carries ratio_in==0
// BEHAVIOUR
//  - Reset (async, reset_n=0): state HALTED, counter 0, clock_enable 0, clock_out 0, ratio_err 0,
//    active and shadow ratio = DEFAULT_RATIO, no pending load.
//  - Counter: in RUNNING, STEP and DRAIN it counts 0..active-1. At count==active-1,
//    clock_enable=1 that cycle, counter->0 next edge, and clock_out toggles.
//    Counter is held at 0 in HALTED. With ratio 1, enable stays high every cycle while running.
//  - Ratio load: ratio_in==0 is ignored and ratio_err pulses. Nonzero values go to the shadow ratio
//    with pending=1. Pending is applied (active<=shadow) on the edge that ends an enable cycle,
//    or immediately if HALTED. A newer load before application overwrites the shadow (last wins).
//  - FSM. Priority for simultaneous requests: halt_req > run_req > step_req.
//    HALTED : run_req -> RUNNING; step_req -> STEP; else stay. Counter starts at 0.
//    RUNNING: halt_req -> DRAIN, or directly to HALTED if clock_enable=1 this cycle.
//             run_req and step_req are ignored.
//    STEP   : on clock_enable -> HALTED (exactly one pulse). halt_req -> DRAIN.
//    DRAIN  : on clock_enable -> HALTED. All requests are ignored.
//  - Latency: request sampled at edge t gives the new state at t+1; the first clock_enable is on
//    cycle t+active.
//  - Reset mid-period aborts it immediately: no enable pulse, clock_out forced 0.
//  - counter_out and state_out are registered. clock_enable is a combinational decode of
//    registered state and counter, so it is glitch-free.
// CONFIGURATION
//  STEP_CNT_EN defined: adds output enable_count[31:0]. It resets to 0, increments on each
//    clock_enable, and wraps 0xFFFFFFFF->0. It is held (not cleared) in HALTED.
//  STEP_CNT_EN undefined: the port and counter do not exist. All other behaviour is identical.
// STRUCTURE
//  - Shared package/include clock_ctrl_defs: the state encodings ST_HALTED..ST_DRAIN and the
//    2-bit state width.
//  - One sub-module, clock_period_counter, holds the counter, the enable decode, the clock_out
//    toggle and the shadow/active ratio registers. This module keeps the FSM and request priority.
// TESTING
//  1 Reset, run_req at t, ratio 2 -> clock_enable on t+2, t+4, t+6; clock_out period 4 cycles.
//  2 RUNNING ratio 4, load ratio 3 mid-period -> current period still 4 cycles, following periods 3.
//  3 HALTED, step_req, ratio 5 -> exactly one enable 5 cycles later, state_out returns to 0.
//  4 RUNNING ratio 6, halt_req at count 2 -> DRAIN, one more enable at count 5, then HALTED with
//    counter 0.
//  5 ratio_load with ratio_in=0 -> ratio_err high 1 cycle, enable spacing unchanged.
//  6 reset_n low at count 3 of ratio 8 -> outputs clear immediately, no enable;
//    with STEP_CNT_EN, enable_count returns to 0.

Source files
------------

// File: rtl/clock_step_controller_pkg.sv
// Shared definitions for the clock step controller: FSM state encoding and
// the state width.
package clock_ctrl_defs;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HALTED  = 2'd0,
    ST_RUNNING = 2'd1,
    ST_STEP    = 2'd2,
    ST_DRAIN   = 2'd3
  } ctrl_state_e;

  // The period counter advances in every state except HALTED.
  function automatic logic is_counting(ctrl_state_e st);
    return st != ST_HALTED;
  endfunction

endpackage

// File: rtl/clock_step_controller_if.sv
// Control/status bundle between a requester and the clock step controller.
// Optional feature macro: STEP_CNT_EN adds the 32-bit enable_count status.
interface clock_step_controller_if
  import clock_ctrl_defs::*;
  #(parameter int CNT_W = 6);

  logic [CNT_W-1:0]   ratio_in;
  logic               ratio_load;
  logic               run_req;
  logic               halt_req;
  logic               step_req;
  logic               clock_enable;
  logic               clock_out;
  logic [CNT_W-1:0]   counter_out;
  logic [STATE_W-1:0] state_out;
  logic               ratio_err;
`ifdef STEP_CNT_EN
  logic [31:0]        enable_count;
`endif

  modport master (
    output ratio_in, ratio_load, run_req, halt_req, step_req,
    input  clock_enable, clock_out, counter_out, state_out, ratio_err
`ifdef STEP_CNT_EN
    , input enable_count
`endif
  );

  modport slave (
    input  ratio_in, ratio_load, run_req, halt_req, step_req,
    output clock_enable, clock_out, counter_out, state_out, ratio_err
`ifdef STEP_CNT_EN
    , output enable_count
`endif
  );

endinterface

// File: rtl/clock_step_controller_period_counter.sv
// Period counter for the clock step controller: counts 0..active-1, decodes
// the enable pulse, toggles the divided clock and owns the shadow/active
// ratio pair. State updates on the falling edge of clock_in.
// Optional feature macro: STEP_CNT_EN adds the enable_count tally.
module clock_period_counter #(
  parameter int CNT_W         = 6,
  parameter int DEFAULT_RATIO = 2
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             counting,
  input  logic [CNT_W-1:0] ratio_in,
  input  logic             ratio_load,
  output logic             clock_enable,
  output logic             clock_out,
  output logic [CNT_W-1:0] counter_out,
  output logic             ratio_err
`ifdef STEP_CNT_EN
  , output logic [31:0]    enable_count
`endif
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] active_reg;
  logic [CNT_W-1:0] shadow_reg;
  logic             pending_reg;
  logic             clk_out_reg;
  logic             err_reg;

  logic             load_ok;
  logic             pending_next;
  logic [CNT_W-1:0] shadow_next;
  logic             apply_now;

  // Enable decodes only registered values, so it cannot glitch.
  assign clock_enable = counting && (count_reg == active_reg - CNT_W'(1));

  // A load arriving on the same edge as an application is taken along with
  // it, so the most recent nonzero request always wins.
  assign load_ok      = ratio_load && (ratio_in != '0);
  assign shadow_next  = load_ok ? ratio_in : shadow_reg;
  assign pending_next = load_ok || pending_reg;
  assign apply_now    = pending_next && (!counting || clock_enable);

  // Period count: held at 0 while halted, wraps after the enable cycle.
  always_ff @(negedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (!counting || clock_enable) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // Divided clock flips at the end of every enable cycle.
  always_ff @(negedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      clk_out_reg <= 1'b0;
    end else if (clock_enable) begin
      clk_out_reg <= ~clk_out_reg;
    end
  end

  // Shadow/active ratio: only a period boundary (or halt) changes the period.
  always_ff @(negedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      active_reg  <= CNT_W'(DEFAULT_RATIO);
      shadow_reg  <= CNT_W'(DEFAULT_RATIO);
      pending_reg <= 1'b0;
    end else begin
      shadow_reg <= shadow_next;
      if (apply_now) begin
        active_reg  <= shadow_next;
        pending_reg <= 1'b0;
      end else begin
        pending_reg <= pending_next;
      end
    end
  end

  // Rejected zero-ratio load is flagged for exactly one cycle.
  always_ff @(negedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= ratio_load && (ratio_in == '0);
    end
  end

  assign clock_out   = clk_out_reg;
  assign counter_out = count_reg;
  assign ratio_err   = err_reg;

`ifdef STEP_CNT_EN
  logic [31:0] enable_count_reg;

  // Running tally of issued enables; wraps naturally at 32 bits.
  always_ff @(negedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      enable_count_reg <= '0;
    end else if (clock_enable) begin
      enable_count_reg <= enable_count_reg + 32'd1;
    end
  end

  assign enable_count = enable_count_reg;
`endif

endmodule

// File: rtl/clock_step_controller.sv
// Clock step controller: run/halt/single-step sequencing of the reduced-rate
// pipeline enable. The FSM and request priority live here; the period
// counter, divided clock and ratio registers live in clock_period_counter.
// Optional feature macro: STEP_CNT_EN adds enable_count on the bus.
module clock_step_controller
  import clock_ctrl_defs::*;
#(
  parameter int CNT_W         = 6,
  parameter int DEFAULT_RATIO = 2
) (
  input  logic                    clock_in,
  input  logic                    reset_n,
  clock_step_controller_if.slave  bus
);

  ctrl_state_e state_reg;
  ctrl_state_e state_next;
  logic        clock_enable;

  clock_period_counter #(
    .CNT_W         (CNT_W),
    .DEFAULT_RATIO (DEFAULT_RATIO)
  ) u_period (
    .clock_in     (clock_in),
    .reset_n      (reset_n),
    .counting     (is_counting(state_reg)),
    .ratio_in     (bus.ratio_in),
    .ratio_load   (bus.ratio_load),
    .clock_enable (clock_enable),
    .clock_out    (bus.clock_out),
    .counter_out  (bus.counter_out),
    .ratio_err    (bus.ratio_err)
`ifdef STEP_CNT_EN
    , .enable_count (bus.enable_count)
`endif
  );

  // State register, updated on the falling edge like the rest of the block.
  always_ff @(negedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_HALTED;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; halt_req outranks run_req, which outranks step_req.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_HALTED: begin
        if (bus.halt_req)      state_next = ST_HALTED;
        else if (bus.run_req)  state_next = ST_RUNNING;
        else if (bus.step_req) state_next = ST_STEP;
      end
      ST_RUNNING: begin
        if (bus.halt_req) state_next = clock_enable ? ST_HALTED : ST_DRAIN;
      end
      ST_STEP: begin
        if (clock_enable)      state_next = ST_HALTED;
        else if (bus.halt_req) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (clock_enable) state_next = ST_HALTED;
      end
      default: state_next = ST_HALTED;
    endcase
  end

  assign bus.clock_enable = clock_enable;
  assign bus.state_out    = state_reg;

endmodule
